// File: rtl/prog_sequencer.sv
// prog_sequencer: run controller for the three-program processor.
// Launches programs 1 -> 2 -> 3 in turn, holding the core in reset for one
// cycle before each program, and aborts on divide-by-zero (program 1 only)
// or when a program exceeds its cycle budget. Every output is a register.
module prog_sequencer #(
  parameter logic [9:0]  PROG1_BASE = 10'd0,
  parameter logic [9:0]  PROG2_BASE = 10'd256,
  parameter logic [9:0]  PROG3_BASE = 10'd512,
  parameter logic [15:0] TIMEOUT    = 16'd4000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Halt,
  input  logic        DivZero,
  output logic [1:0]  ProgState,
  output logic        CoreReset,
  output logic [9:0]  StartAddr,
  output logic        Busy,
  output logic        Done,
  output logic [1:0]  Fault,
  output logic [15:0] CycleCount
);

  // Controller states.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LAUNCH = 3'd1;
  localparam logic [2:0] ST_RUN    = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_FAULT  = 3'd4;

  // ProgState encodings.
  localparam logic [1:0] PROG_NONE = 2'b00;
  localparam logic [1:0] PROG_1    = 2'b01;
  localparam logic [1:0] PROG_3    = 2'b11;

  // Fault encodings.
  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_DIVZERO = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  logic [2:0]  state;
  logic [2:0]  state_next;
  logic [1:0]  prog_next;
  logic [9:0]  addr_next;
  logic [1:0]  fault_next;
  logic [15:0] count_next;
  logic [15:0] count_inc;
  logic        timeout_hit;

  // Saturating increment so a long run can never wrap the counter.
  assign count_inc   = (CycleCount == 16'hFFFF) ? CycleCount : CycleCount + 16'd1;
  // The budget is spent on the cycle whose increment would reach TIMEOUT.
  assign timeout_hit = (CycleCount == TIMEOUT - 16'd1);

  // Next-state and next-output decode.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // (an unassigned path in combinational logic infers a latch).
    state_next = state;
    prog_next  = ProgState;
    addr_next  = StartAddr;
    fault_next = Fault;
    count_next = CycleCount;

    case (state)
      ST_IDLE, ST_DONE, ST_FAULT: begin
        if (Start) begin
          state_next = ST_LAUNCH;
          prog_next  = PROG_1;
          addr_next  = PROG1_BASE;
          fault_next = FAULT_NONE;
          count_next = '0;
        end else if (state == ST_DONE) begin
          state_next = ST_IDLE;
        end
      end

      ST_LAUNCH: begin
        state_next = ST_RUN;
        count_next = '0;
      end

      ST_RUN: begin
        if (DivZero && (ProgState == PROG_1)) begin
          // Divide-by-zero outranks a simultaneous Halt.
          state_next = ST_FAULT;
          prog_next  = PROG_NONE;
          fault_next = FAULT_DIVZERO;
          count_next = count_inc;
        end else if (Halt && (ProgState != PROG_3)) begin
          state_next = ST_LAUNCH;
          prog_next  = ProgState + 2'd1;
          addr_next  = (ProgState == PROG_1) ? PROG2_BASE : PROG3_BASE;
          count_next = '0;
        end else if (Halt) begin
          state_next = ST_DONE;
          prog_next  = PROG_NONE;
          count_next = count_inc;
        end else if (timeout_hit) begin
          // Counter is frozen at TIMEOUT-1 so it reports the last RUN value.
          state_next = ST_FAULT;
          prog_next  = PROG_NONE;
          fault_next = FAULT_TIMEOUT;
        end else begin
          count_next = count_inc;
        end
      end

      default: begin
        state_next = ST_IDLE;
        prog_next  = PROG_NONE;
      end
    endcase
  end

  // State and output registers; status flags are decoded from the next state
  // so they line up with the state they describe.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (Reset) begin
      state      <= ST_IDLE;
      ProgState  <= PROG_NONE;
      CoreReset  <= 1'b1;
      StartAddr  <= PROG1_BASE;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Fault      <= FAULT_NONE;
      CycleCount <= '0;
    end else begin
      state      <= state_next;
      ProgState  <= prog_next;
      CoreReset  <= (state_next != ST_RUN);
      StartAddr  <= addr_next;
      Busy       <= (state_next == ST_LAUNCH) || (state_next == ST_RUN);
      Done       <= (state_next == ST_DONE);
      Fault      <= fault_next;
      CycleCount <= count_next;
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: scoreboard bench for prog_sequencer.
// Stimulus pushes the expected output snapshot for every output change it
// provokes; a monitor per instance pops and compares whenever the DUT's
// control outputs change. Unexpected changes are failures too.
module tb_prog_sequencer;

  typedef struct packed {
    logic [1:0] prog;
    logic       core_reset;
    logic [9:0] addr;
    logic       busy;
    logic       done;
    logic [1:0] fault;
  } snap_t;

  typedef struct packed {
    snap_t       snap;
    logic        chk_cnt;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: default budget, used for the program-flow tests.
  logic        a_reset = 1'b1, a_start = 1'b0, a_halt = 1'b0, a_divzero = 1'b0;
  logic [1:0]  a_prog, a_fault;
  logic        a_core_reset, a_busy, a_done;
  logic [9:0]  a_addr;
  logic [15:0] a_cnt;

  // Instance B: TIMEOUT = 8, used for the timeout test.
  logic        b_reset = 1'b1, b_start = 1'b0, b_halt = 1'b0, b_divzero = 1'b0;
  logic [1:0]  b_prog, b_fault;
  logic        b_core_reset, b_busy, b_done;
  logic [9:0]  b_addr;
  logic [15:0] b_cnt;

  prog_sequencer dut_a (
    .CLK(clk), .Reset(a_reset), .Start(a_start), .Halt(a_halt), .DivZero(a_divzero),
    .ProgState(a_prog), .CoreReset(a_core_reset), .StartAddr(a_addr), .Busy(a_busy),
    .Done(a_done), .Fault(a_fault), .CycleCount(a_cnt)
  );

  prog_sequencer #(.TIMEOUT(16'd8)) dut_b (
    .CLK(clk), .Reset(b_reset), .Start(b_start), .Halt(b_halt), .DivZero(b_divzero),
    .ProgState(b_prog), .CoreReset(b_core_reset), .StartAddr(b_addr), .Busy(b_busy),
    .Done(b_done), .Fault(b_fault), .CycleCount(b_cnt)
  );

  exp_t q_a[$];
  exp_t q_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic snap_t mk(input logic [1:0] prog, input logic cr, input logic [9:0] addr,
                               input logic busy, input logic done, input logic [1:0] fault);
    snap_t s;
    s.prog = prog; s.core_reset = cr; s.addr = addr;
    s.busy = busy; s.done = done; s.fault = fault;
    return s;
  endfunction

  task automatic push_a(input snap_t s, input logic chk, input logic [15:0] cnt);
    exp_t e;
    e.snap = s; e.chk_cnt = chk; e.cnt = cnt;
    q_a.push_back(e);
  endtask

  task automatic push_b(input snap_t s, input logic chk, input logic [15:0] cnt);
    exp_t e;
    e.snap = s; e.chk_cnt = chk; e.cnt = cnt;
    q_b.push_back(e);
  endtask

  // Monitor A: on any change of the control outputs, pop and compare.
  snap_t cur_a, prev_a;
  int    ev_a = 0;
  always @(negedge clk) begin
    exp_t e;
    cur_a = {a_prog, a_core_reset, a_addr, a_busy, a_done, a_fault};
    if (cur_a !== prev_a) begin
      prev_a = cur_a;
      if (q_a.size() == 0) begin
        check($sformatf("A ev%0d unexpected output change", ev_a), 32'(cur_a), 32'hFFFF_FFFF);
      end else begin
        e = q_a.pop_front();
        check($sformatf("A ev%0d outputs", ev_a), 32'(cur_a), 32'(e.snap));
        if (e.chk_cnt) check($sformatf("A ev%0d CycleCount", ev_a), 32'(a_cnt), 32'(e.cnt));
      end
      ev_a++;
    end
  end

  // Monitor B: same scheme for the short-budget instance.
  snap_t cur_b, prev_b;
  int    ev_b = 0;
  always @(negedge clk) begin
    exp_t e;
    cur_b = {b_prog, b_core_reset, b_addr, b_busy, b_done, b_fault};
    if (cur_b !== prev_b) begin
      prev_b = cur_b;
      if (q_b.size() == 0) begin
        check($sformatf("B ev%0d unexpected output change", ev_b), 32'(cur_b), 32'hFFFF_FFFF);
      end else begin
        e = q_b.pop_front();
        check($sformatf("B ev%0d outputs", ev_b), 32'(cur_b), 32'(e.snap));
        if (e.chk_cnt) check($sformatf("B ev%0d CycleCount", ev_b), 32'(b_cnt), 32'(e.cnt));
      end
      ev_b++;
    end
  end

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected snapshots used repeatedly.
  snap_t s_reset, s_l1, s_r1, s_l2, s_r2, s_l3, s_r3;

  initial begin
    s_reset = mk(2'b00, 1'b1, 10'd0,   1'b0, 1'b0, 2'b00);
    s_l1    = mk(2'b01, 1'b1, 10'd0,   1'b1, 1'b0, 2'b00);
    s_r1    = mk(2'b01, 1'b0, 10'd0,   1'b1, 1'b0, 2'b00);
    s_l2    = mk(2'b10, 1'b1, 10'd256, 1'b1, 1'b0, 2'b00);
    s_r2    = mk(2'b10, 1'b0, 10'd256, 1'b1, 1'b0, 2'b00);
    s_l3    = mk(2'b11, 1'b1, 10'd512, 1'b1, 1'b0, 2'b00);
    s_r3    = mk(2'b11, 1'b0, 10'd512, 1'b1, 1'b0, 2'b00);

    // Reset state of both instances.
    push_a(s_reset, 1'b1, 16'd0);
    push_b(s_reset, 1'b1, 16'd0);
    cyc(2);
    a_reset = 1'b0;

    // Normal run: Halt on RUN cycles 10, 20, 30.
    a_start = 1'b1;
    push_a(s_l1, 1'b1, 16'd0);
    push_a(s_r1, 1'b1, 16'd0);
    cyc(1); a_start = 1'b0;
    cyc(1);                       // RUN cycle 1 of program 1
    cyc(9);
    a_halt = 1'b1;
    push_a(s_l2, 1'b1, 16'd0);
    push_a(s_r2, 1'b1, 16'd0);
    cyc(1); a_halt = 1'b0;
    cyc(1);
    cyc(19);
    a_halt = 1'b1;
    push_a(s_l3, 1'b1, 16'd0);
    push_a(s_r3, 1'b1, 16'd0);
    cyc(1); a_halt = 1'b0;
    cyc(1);
    cyc(29);
    a_halt = 1'b1;
    push_a(mk(2'b00, 1'b1, 10'd512, 1'b0, 1'b1, 2'b00), 1'b1, 16'd30);  // DONE
    push_a(mk(2'b00, 1'b1, 10'd512, 1'b0, 1'b0, 2'b00), 1'b1, 16'd30);  // IDLE
    cyc(1); a_halt = 1'b0;
    cyc(3);

    // Divide-by-zero on RUN cycle 5 of program 1.
    a_start = 1'b1;
    push_a(s_l1, 1'b1, 16'd0);
    push_a(s_r1, 1'b1, 16'd0);
    cyc(1); a_start = 1'b0;
    cyc(1);
    cyc(4);
    a_divzero = 1'b1;
    push_a(mk(2'b00, 1'b1, 10'd0, 1'b0, 1'b0, 2'b01), 1'b0, 16'd0);
    cyc(1); a_divzero = 1'b0;
    a_halt = 1'b1;                // ignored in FAULT
    cyc(2); a_halt = 1'b0;
    cyc(1);

    // Start clears Fault and relaunches program 1.
    a_start = 1'b1;
    push_a(s_l1, 1'b1, 16'd0);
    push_a(s_r1, 1'b1, 16'd0);
    cyc(1); a_start = 1'b0;
    cyc(1);

    // DivZero and Halt together in program 1: fault wins.
    a_divzero = 1'b1; a_halt = 1'b1;
    push_a(mk(2'b00, 1'b1, 10'd0, 1'b0, 1'b0, 2'b01), 1'b0, 16'd0);
    cyc(1); a_divzero = 1'b0; a_halt = 1'b0;
    cyc(2);

    // Quick pass to program 3; DivZero there is ignored; Start held through DONE.
    a_start = 1'b1;
    push_a(s_l1, 1'b1, 16'd0);
    push_a(s_r1, 1'b1, 16'd0);
    cyc(1); a_start = 1'b0;
    cyc(1);
    a_halt = 1'b1;
    push_a(s_l2, 1'b1, 16'd0);
    push_a(s_r2, 1'b1, 16'd0);
    cyc(1); a_halt = 1'b0;
    cyc(1);
    a_halt = 1'b1;
    push_a(s_l3, 1'b1, 16'd0);
    push_a(s_r3, 1'b1, 16'd0);
    cyc(1); a_halt = 1'b0;
    cyc(1);                       // RUN cycle 1 of program 3
    cyc(2);
    a_divzero = 1'b1;             // RUN cycle 3: no effect
    cyc(1); a_divzero = 1'b0;     // RUN cycle 4
    a_halt = 1'b1; a_start = 1'b1;
    push_a(mk(2'b00, 1'b1, 10'd512, 1'b0, 1'b1, 2'b00), 1'b1, 16'd4);   // DONE
    push_a(s_l1, 1'b1, 16'd0);    // straight back to LAUNCH
    push_a(s_r1, 1'b1, 16'd0);
    cyc(1); a_halt = 1'b0;
    cyc(1); a_start = 1'b0;
    cyc(1);                       // RUN cycle 1 of program 1

    // Reset mid-run in program 2; Start during RUN is ignored.
    a_halt = 1'b1;
    push_a(s_l2, 1'b1, 16'd0);
    push_a(s_r2, 1'b1, 16'd0);
    cyc(1); a_halt = 1'b0;
    cyc(1);
    a_start = 1'b1;
    cyc(2); a_start = 1'b0;
    cyc(3);
    a_reset = 1'b1; a_start = 1'b1;
    push_a(s_reset, 1'b1, 16'd0);
    cyc(1); a_reset = 1'b0; a_start = 1'b0;
    cyc(3);

    // Timeout on instance B: program 2 runs without Halt for 8 cycles.
    b_reset = 1'b0;
    cyc(1);
    b_start = 1'b1;
    push_b(s_l1, 1'b1, 16'd0);
    push_b(s_r1, 1'b1, 16'd0);
    cyc(1); b_start = 1'b0;
    cyc(1);
    b_halt = 1'b1;
    push_b(s_l2, 1'b1, 16'd0);
    push_b(s_r2, 1'b1, 16'd0);
    cyc(1); b_halt = 1'b0;
    cyc(1);                       // RUN cycle 1 of program 2
    push_b(mk(2'b00, 1'b1, 10'd256, 1'b0, 1'b0, 2'b10), 1'b1, 16'd7);
    cyc(8);                       // edge ending RUN cycle 8 enters FAULT
    for (int i = 0; i < 3; i++) begin
      b_halt = 1'b1; cyc(1);
      b_halt = 1'b0; cyc(1);
    end
    cyc(2);

    check("A queue drained", 32'(q_a.size()), 32'd0);
    check("B queue drained", 32'(q_b.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
